// File: rtl/ov7670_stream_generator_pkg.sv
// rtl/ov7670_stream_generator_pkg.sv - shared types and helpers for the OV7670 stream generator
// Package ov7670_pkg: test-pattern and FSM enums, colour-bar table, RGB444 byte packing.
package ov7670_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_ZEBRA = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } gen_state_e;

  // Colour bars, left to right.
  localparam logic [11:0] BAR_LUT [0:7] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // OV7670 RGB444 wire order: first byte xR, second byte GB.
  function automatic logic [7:0] rgb444_byte(input logic [11:0] rgb, input logic odd);
    return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_stream_generator_if.sv
// rtl/ov7670_stream_generator_if.sv - OV7670 camera bus (vsync/href/d)
// Ports: vsync (frame sync, active high), href (active bytes), d (pixel byte).
// master = sensor side (drives), slave = capture side (receives).
interface ov7670_stream_generator_if;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  modport master (output vsync, href, d);
  modport slave  (input  vsync, href, d);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// rtl/ov7670_pattern_gen.sv - registered test-pattern source, (x,y,pattern,solid) -> rgb444
// Ports: clk; x pixel index; y active-line index; pattern select; solid colour;
//        rgb registered RGB444 result, one cycle after x/y.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int STRIPE_H = 32
) (
  input  logic        clk,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  pattern_e    pattern,
  input  logic [11:0] solid,
  output logic [11:0] rgb
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar;
  logic [3:0] ramp;
  logic       stripe_odd;

  always_comb begin
    bar        = 3'(32'(x) / 32'(BAR_W));
    ramp       = 4'((32'(x) * 32'd16) / 32'(H_ACTIVE));
    stripe_odd = ((32'(y) / 32'(STRIPE_H)) % 32'd2) != 32'd0;
  end

  always_ff @(posedge clk) begin
    case (pattern)
      PAT_BARS:  rgb <= BAR_LUT[bar];
      PAT_RAMP:  rgb <= {ramp, ramp, ramp};
      PAT_ZEBRA: rgb <= stripe_odd ? 12'h000 : 12'hFFF;
      default:   rgb <= solid;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_generator.sv
// rtl/ov7670_stream_generator.sv - OV7670 RGB444 camera emulator with internal test patterns
// Ports: clk, rst (sync active high); enable (start frames while high); pattern, solid_rgb
//        (latched at frame start); cam (vsync/href/d master); frame_start, frame_done pulses;
//        busy; frame_count (completed frames, wrapping).
// Option OV7670_GEN_EXT_PIXEL_EN: adds ext_pixel/ext_valid/ext_ready/underrun; pattern 3
//        then streams external pixels instead of solid_rgb.
module ov7670_stream_generator
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int STRIPE_H    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
`ifdef OV7670_GEN_EXT_PIXEL_EN
  input  logic [11:0] ext_pixel,
  input  logic        ext_valid,
  output logic        ext_ready,
  output logic        underrun,
`endif
  ov7670_stream_generator_if.master cam,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int          H_TOTAL = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_ACT_B = 16'(2 * H_ACTIVE);
  localparam logic [15:0] VS_LAST = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST = 16'(V_FRONT - 1);

  gen_state_e  state;
  logic [15:0] h_cnt, v_cnt;
  pattern_e    pat_q;
  logic [11:0] solid_q;

  logic [15:0] nxt_h, la_h, la_x, la_y;
  logic        line_end, nx_active, la_wrap, la_active;
  logic [11:0] gen_rgb, src_rgb;

  // Outputs are registered from the position one step ahead of the counters (nxt_h).
  // The pattern source adds another register, so it is fed two positions ahead (la_*).
  always_comb begin
    line_end  = (h_cnt == H_LAST);
    nxt_h     = line_end ? 16'd0 : h_cnt + 16'd1;
    nx_active = ((state == ST_ACTIVE) && !(line_end && v_cnt == VA_LAST) && (nxt_h < H_ACT_B)) ||
                ((state == ST_VBACK) && line_end && v_cnt == VB_LAST);

    la_wrap   = (32'(h_cnt) + 32'd2) >= 32'(H_TOTAL);
    la_h      = la_wrap ? 16'(32'(h_cnt) + 32'd2 - 32'(H_TOTAL)) : 16'(32'(h_cnt) + 32'd2);
    la_x      = la_h >> 1;
    la_y      = (state == ST_ACTIVE) ? v_cnt + {15'd0, la_wrap} : 16'd0;
    la_active = (la_h < H_ACT_B) &&
                (((state == ST_ACTIVE) && !(la_wrap && v_cnt == VA_LAST)) ||
                 ((state == ST_VBACK) && la_wrap && v_cnt == VB_LAST));
  end

  ov7670_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .STRIPE_H (STRIPE_H)
  ) u_pattern_gen (
    .clk     (clk),
    .x       (la_x),
    .y       (la_y),
    .pattern (pat_q),
    .solid   (solid_q),
    .rgb     (gen_rgb)
  );

`ifdef OV7670_GEN_EXT_PIXEL_EN
  logic [11:0] ext_q, ext_rgb;

  // ext_ready leads its even byte by one cycle, so the accepted pixel can be
  // registered straight into d; ext_q holds it for the following GB byte.
  always_comb begin
    ext_rgb = ext_ready ? (ext_valid ? ext_pixel : 12'h000) : ext_q;
    src_rgb = (pat_q == PAT_SOLID) ? ext_rgb : gen_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_ready <= 1'b0;
      underrun  <= 1'b0;
      ext_q     <= 12'h000;
    end else begin
      ext_ready <= la_active && !la_h[0] && (pat_q == PAT_SOLID);
      if (ext_ready) begin
        ext_q <= ext_rgb;
        if (!ext_valid) underrun <= 1'b1;
      end
    end
  end
`else
  always_comb src_rgb = gen_rgb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      h_cnt       <= 16'd0;
      v_cnt       <= 16'd0;
      pat_q       <= PAT_BARS;
      solid_q     <= 12'h000;
      cam.vsync   <= 1'b0;
      cam.href    <= 1'b0;
      cam.d       <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      cam.href    <= nx_active;
      cam.d       <= nx_active ? rgb444_byte(src_rgb, nxt_h[0]) : 8'h00;
      h_cnt       <= nxt_h;
      v_cnt       <= line_end ? v_cnt + 16'd1 : v_cnt;
      case (state)
        ST_IDLE: begin
          h_cnt <= 16'd0;
          v_cnt <= 16'd0;
          if (enable) begin
            state       <= ST_VSYNC;
            cam.vsync   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            pat_q       <= pattern_e'(pattern);
            solid_q     <= solid_rgb;
          end
        end
        ST_VSYNC: if (line_end && v_cnt == VS_LAST) begin
          state     <= ST_VBACK;
          v_cnt     <= 16'd0;
          cam.vsync <= 1'b0;
        end
        ST_VBACK: if (line_end && v_cnt == VB_LAST) begin
          state <= ST_ACTIVE;
          v_cnt <= 16'd0;
        end
        ST_ACTIVE: if (line_end && v_cnt == VA_LAST) begin
          state <= ST_VFRONT;
          v_cnt <= 16'd0;
        end
        ST_VFRONT: begin
          // frame_done lands on the final VFRONT cycle, together with the count.
          if (h_cnt == H_LAST - 16'd1 && v_cnt == VF_LAST) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
          if (line_end && v_cnt == VF_LAST) begin
            v_cnt <= 16'd0;
            if (enable) begin
              state       <= ST_VSYNC;
              cam.vsync   <= 1'b1;
              frame_start <= 1'b1;
              pat_q       <= pattern_e'(pattern);
              solid_q     <= solid_rgb;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_stream_generator.sv
// tb/tb_ov7670_stream_generator.sv - self-checking bench for ov7670_stream_generator
module tb_ov7670_stream_generator;

  localparam int HA = 8, VA = 4, HB = 4, VS = 1, VB = 1, VF = 1, SH = 2;
  localparam int HT = 2 * HA + HB;
  localparam int FRAME = HT * (VS + VB + VA + VF);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        frame_start, frame_done, busy;
  logic [15:0] frame_count;
  logic [11:0] ext_px = 12'h000;
  logic        ext_ready, underrun;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  ov7670_stream_generator_if cam ();

  always #5 clk = ~clk;

  ov7670_stream_generator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .STRIPE_H(SH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern     (pattern),
    .solid_rgb   (solid_rgb),
`ifdef OV7670_GEN_EXT_PIXEL_EN
    .ext_pixel   (ext_px),
    .ext_valid   (1'b1),
    .ext_ready   (ext_ready),
    .underrun    (underrun),
`endif
    .cam         (cam),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_count (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_rgb(input int pat, input logic [11:0] sol, input int x, input int y);
    logic [3:0] r;
    case (pat)
      0: return bars[x / (HA / 8)];
      1: begin r = 4'(x * 16 / HA); return {r, r, r}; end
      2: return ((y / SH) % 2 == 0) ? 12'hFFF : 12'h000;
      default: return sol;
    endcase
  endfunction

  task automatic check_frame_cycle(input int t, input int pat, input logic [11:0] sol, input int cnt0);
    int line, h;
    logic act;
    logic [11:0] rgb;
    logic [7:0] ed;
    line = (t - 1) / HT;
    h    = (t - 1) % HT;
    act  = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
    rgb  = ref_rgb(pat, sol, h / 2, line - VS - VB);
    ed   = !act ? 8'h00 : (h % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
    chk($sformatf("vsync t=%0d", t), 32'(cam.vsync), 32'(line < VS));
    chk($sformatf("href t=%0d", t), 32'(cam.href), 32'(act));
    chk($sformatf("d t=%0d pat=%0d", t, pat), 32'(cam.d), 32'(ed));
    chk($sformatf("frame_start t=%0d", t), 32'(frame_start), 32'(t == 1));
    chk($sformatf("frame_done t=%0d", t), 32'(frame_done), 32'(t == FRAME));
    chk($sformatf("busy t=%0d", t), 32'(busy), 32'd1);
    chk($sformatf("frame_count t=%0d", t), 32'(frame_count), 32'(16'(t == FRAME ? cnt0 + 1 : cnt0)));
  endtask

  task automatic run_frame(input int pat, input logic [11:0] sol, input int nxt_pat,
                           input logic [11:0] nxt_sol, input int drop_at, input int rst_at);
    int glitch;
    glitch = $urandom_range(2, FRAME - 2);
    ext_px = sol;
    for (int t = 1; t <= FRAME; t++) begin
      @(negedge clk);
      check_frame_cycle(t, pat, sol, exp_count);
      if (t == rst_at) begin
        rst = 1'b1;
        return;
      end
      if (t == glitch) begin
        pattern   = 2'($urandom);
        solid_rgb = 12'($urandom);
      end
      if (t == drop_at) enable = 1'b0;
      if (t == FRAME) begin
        pattern   = 2'(nxt_pat);
        solid_rgb = nxt_sol;
      end
    end
    exp_count++;
  endtask

  int          pats [0:5];
  logic [11:0] sols [0:5];

  initial begin
    pats = '{0, 1, 2, 3, 0, 0};
    pats[4] = int'($urandom_range(0, 3));
    pats[5] = int'($urandom_range(0, 3));
    for (int i = 0; i < 6; i++) sols[i] = 12'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst vsync", 32'(cam.vsync), 32'd0);
    chk("rst href", 32'(cam.href), 32'd0);
    chk("rst d", 32'(cam.d), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);

    enable = 1'b1;
    @(negedge clk);
    chk("enable under rst", 32'(cam.vsync), 32'd0);

    rst       = 1'b0;
    pattern   = 2'(pats[0]);
    solid_rgb = sols[0];

    for (int f = 0; f < 5; f++)
      run_frame(pats[f], sols[f], pats[f + 1], sols[f + 1], (f == 4) ? 60 : -1, -1);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("idle vsync i=%0d", i), 32'(cam.vsync), 32'd0);
      chk($sformatf("idle href i=%0d", i), 32'(cam.href), 32'd0);
      chk($sformatf("idle busy i=%0d", i), 32'(busy), 32'd0);
      chk($sformatf("idle frame_start i=%0d", i), 32'(frame_start), 32'd0);
      chk($sformatf("idle frame_count i=%0d", i), 32'(frame_count), 32'(16'(exp_count)));
    end

    enable    = 1'b1;
    pattern   = 2'(pats[5]);
    solid_rgb = sols[5];
    run_frame(pats[5], sols[5], 0, 12'h000, -1, 70);

    @(negedge clk);
    rst = 1'b0;
    chk("midrst vsync", 32'(cam.vsync), 32'd0);
    chk("midrst href", 32'(cam.href), 32'd0);
    chk("midrst d", 32'(cam.d), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst frame_done", 32'(frame_done), 32'd0);
    chk("midrst frame_count", 32'(frame_count), 32'd0);

    @(negedge clk);
    chk("restart frame_start", 32'(frame_start), 32'd1);
    chk("restart vsync", 32'(cam.vsync), 32'd1);
    chk("restart busy", 32'(busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
